gbe_rx_eof_counter: RTL and testbench
=====================================

// Module: gbe_rx_eof_counter
// PURPOSE
//  Frame-statistics stage on the 10GbE core's RX user interface, in the user_clk domain.
//  Counts good and bad received frames and measures frame lengths in 64-bit words.
//  Its registered outputs drive the user_data_in inputs of the gbe0 rxeofctr,
//  rxbadctr and rx length OPB software registers, downstream of this block.
// PARAMETERS
//  CTR_WIDTH  32  width of eof_count / bad_count
//  LEN_WIDTH  16  width of last_len / max_len, in words
//  SATURATE   0   0: counters wrap to 0 at all-ones; 1: counters hold at all-ones
// PORTS
//  user_clk      in   1          RX user clock; the only clock
//  user_rst_n    in   1          asynchronous, active-low reset
//  rx_valid      in   1          RX data word valid
//  rx_eof        in   1          last word of frame; qualified by rx_valid
//  rx_bad_frame  in   1          frame failed CRC/length checks; qualified by rx_valid&rx_eof
//  ctr_en        in   1          count enable, from software register
//  ctr_clr       in   1          synchronous clear, level, from software register
//  eof_count     out  CTR_WIDTH  good frames received
//  bad_count     out  CTR_WIDTH  bad frames received
//  last_len      out  LEN_WIDTH  length of most recent frame, good or bad
//  max_len       out  LEN_WIDTH  longest frame since clear
//  ctr_ovf       out  1          sticky: a counter wrapped or hit saturation
// BEHAVIOUR
//  - Reset: user_rst_n low clears all outputs, word_cnt and state (IDLE), without waiting for a clock.
//    Deassertion is taken synchronously at the next user_clk edge.
//  - Events are sampled on the user_clk rising edge. All outputs are registered.
//    An event sampled at edge N is visible on the outputs after edge N (latency 1).
//  - good_eof = rx_valid & rx_eof & ~rx_bad_frame.
//  - bad_eof  = rx_valid & rx_eof &  rx_bad_frame.
//  - rx_eof and rx_bad_frame are ignored while rx_valid is low.
//  - Counters increment by 1 on good_eof / bad_eof, and only when ctr_en=1.
//  - With ctr_en=0 the counters hold, but the frame FSM and length logic keep running.
//  - ctr_clr=1: eof_count, bad_count, last_len, max_len and ctr_ovf are forced to 0 every cycle while high.
//    ctr_clr beats a simultaneous increment; that event is lost.
//    ctr_clr does not reset the FSM or word_cnt, so a frame in flight is measured correctly.
//  - Counter overflow, SATURATE=0: all-ones + 1 -> 0, and ctr_ovf <= 1.
//  - Counter overflow, SATURATE=1: the counter stays at all-ones and ctr_ovf <= 1 on each attempted increment.
//  - ctr_ovf is sticky; only ctr_clr or reset clears it.
//  - Frame FSM, 2 states; word_cnt is LEN_WIDTH bits and saturates at all-ones:
//    IDLE:     rx_valid & ~rx_eof -> IN_FRAME, word_cnt <= 1.
//    IDLE:     rx_valid & rx_eof  -> stay IDLE, frame length = 1.
//    IN_FRAME: rx_valid & ~rx_eof -> word_cnt <= sat(word_cnt+1).
//    IN_FRAME: rx_valid & rx_eof  -> IDLE, frame length = sat(word_cnt+1), word_cnt <= 0.
//    rx_valid=0 -> hold state and word_cnt; gaps inside a frame are legal.
//  - On any eof: last_len <= frame length; max_len <= max(max_len, frame length).
//    This update happens regardless of ctr_en and of rx_bad_frame.
//  - An eof in the same cycle as ctr_clr=1 is measured by the FSM, but last_len and max_len stay 0.
//  - Back-to-back frames (eof followed by valid on the next cycle) need no idle cycle.
// TESTING
//  1. Reset: pulse user_rst_n low mid-frame without a clock edge
//     -> all outputs 0 immediately; the next frame of 4 words gives last_len=4.
//  2. Frame mix with ctr_en=1: 3 good frames of 8 words, 1 bad frame of 2 words, 1 single-word frame
//     -> eof_count=4, bad_count=1, last_len=1, max_len=8.
//  3. Wrap with SATURATE=0: force eof_count to 0xFFFFFFFF, then 1 good eof
//     -> eof_count=0, ctr_ovf=1. Repeat with SATURATE=1 -> eof_count=0xFFFFFFFF, ctr_ovf=1.
//  4. Clear priority: ctr_clr=1 in the same cycle as a good eof -> eof_count=0 and last_len=0.
//     After ctr_clr falls, the next eof gives eof_count=1.
//  5. Enable gating: with ctr_en=0 send 5 good frames of 6 words -> eof_count unchanged, last_len=6.
//  6. Length saturation: LEN_WIDTH=4, one 20-word frame with rx_valid gaps -> last_len=15, max_len=15.

Source files
------------

// File: rtl/gbe_rx_eof_counter.sv
// RX frame statistics for the 10GbE user interface: good/bad frame counters,
// last and maximum frame length in 64-bit words, and a sticky overflow flag.
module gbe_rx_eof_counter #(
  parameter int unsigned CTR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH = 16,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic                 user_clk,
  input  logic                 user_rst_n,
  input  logic                 rx_valid,
  input  logic                 rx_eof,
  input  logic                 rx_bad_frame,
  input  logic                 ctr_en,
  input  logic                 ctr_clr,
  output logic [CTR_WIDTH-1:0] eof_count,
  output logic [CTR_WIDTH-1:0] bad_count,
  output logic [LEN_WIDTH-1:0] last_len,
  output logic [LEN_WIDTH-1:0] max_len,
  output logic                 ctr_ovf
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] IN_FRAME = 1'b1;

  localparam logic [CTR_WIDTH-1:0] CTR_ONE = {{(CTR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]           state;
  logic [LEN_WIDTH-1:0] word_cnt;
  logic [LEN_WIDTH-1:0] word_cnt_inc;
  logic [LEN_WIDTH-1:0] frame_len;
  logic                 any_eof;
  logic                 good_eof;
  logic                 bad_eof;
  logic [CTR_WIDTH-1:0] eof_next;
  logic [CTR_WIDTH-1:0] bad_next;
  logic                 eof_at_max;
  logic                 bad_at_max;

  assign any_eof  = rx_valid & rx_eof;
  assign good_eof = any_eof & ~rx_bad_frame;
  assign bad_eof  = any_eof &  rx_bad_frame;

  // word_cnt sticks at all-ones so oversize frames report the maximum length
  assign word_cnt_inc = (&word_cnt) ? word_cnt : word_cnt + LEN_ONE;
  assign frame_len    = (state == IDLE) ? LEN_ONE : word_cnt_inc;

  assign eof_at_max = &eof_count;
  assign bad_at_max = &bad_count;
  assign eof_next   = eof_at_max ? (SATURATE ? eof_count : '0) : eof_count + CTR_ONE;
  assign bad_next   = bad_at_max ? (SATURATE ? bad_count : '0) : bad_count + CTR_ONE;

  // Frame FSM is deliberately outside the ctr_clr domain so a frame in
  // flight during a clear is still measured in full.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state    <= IDLE;
      word_cnt <= '0;
    end else if (rx_valid) begin
      if (rx_eof) begin
        state    <= IDLE;
        word_cnt <= '0;
      end else if (state == IDLE) begin
        state    <= IN_FRAME;
        word_cnt <= LEN_ONE;
      end else begin
        word_cnt <= word_cnt_inc;
      end
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      eof_count <= '0;
      bad_count <= '0;
      last_len  <= '0;
      max_len   <= '0;
      ctr_ovf   <= 1'b0;
    end else if (ctr_clr) begin
      eof_count <= '0;
      bad_count <= '0;
      last_len  <= '0;
      max_len   <= '0;
      ctr_ovf   <= 1'b0;
    end else begin
      if (any_eof) begin
        last_len <= frame_len;
        if (frame_len > max_len) max_len <= frame_len;
      end
      if (ctr_en && good_eof) begin
        eof_count <= eof_next;
        if (eof_at_max) ctr_ovf <= 1'b1;
      end
      if (ctr_en && bad_eof) begin
        bad_count <= bad_next;
        if (bad_at_max) ctr_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gbe_rx_eof_counter.sv
// Self-checking bench: one default instance plus two narrow instances (wrap and
// saturate) share stimulus; directed table, corner sequences, random vs model.
module tb_gbe_rx_eof_counter;

  logic user_clk, user_rst_n;
  logic rx_valid, rx_eof, rx_bad_frame, ctr_en, ctr_clr;

  logic [31:0] a_eof, a_bad;
  logic [15:0] a_last, a_max;
  logic        a_ovf;
  logic [3:0]  w_eof, w_bad, w_last, w_max;
  logic        w_ovf;
  logic [3:0]  s_eof, s_bad, s_last, s_max;
  logic        s_ovf;

  gbe_rx_eof_counter dut_a (
    .user_clk(user_clk), .user_rst_n(user_rst_n), .rx_valid(rx_valid), .rx_eof(rx_eof),
    .rx_bad_frame(rx_bad_frame), .ctr_en(ctr_en), .ctr_clr(ctr_clr),
    .eof_count(a_eof), .bad_count(a_bad), .last_len(a_last), .max_len(a_max), .ctr_ovf(a_ovf));

  gbe_rx_eof_counter #(.CTR_WIDTH(4), .LEN_WIDTH(4), .SATURATE(1'b0)) dut_w (
    .user_clk(user_clk), .user_rst_n(user_rst_n), .rx_valid(rx_valid), .rx_eof(rx_eof),
    .rx_bad_frame(rx_bad_frame), .ctr_en(ctr_en), .ctr_clr(ctr_clr),
    .eof_count(w_eof), .bad_count(w_bad), .last_len(w_last), .max_len(w_max), .ctr_ovf(w_ovf));

  gbe_rx_eof_counter #(.CTR_WIDTH(4), .LEN_WIDTH(4), .SATURATE(1'b1)) dut_s (
    .user_clk(user_clk), .user_rst_n(user_rst_n), .rx_valid(rx_valid), .rx_eof(rx_eof),
    .rx_bad_frame(rx_bad_frame), .ctr_en(ctr_en), .ctr_clr(ctr_clr),
    .eof_count(s_eof), .bad_count(s_bad), .last_len(s_last), .max_len(s_max), .ctr_ovf(s_ovf));

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: frame length is simply the number of valid words seen
  // since the frame started, clipped to the length field; counters are integers.
  longint cmax [3] = '{64'hFFFF_FFFF, 64'd15, 64'd15};
  longint lmax [3] = '{64'd65535, 64'd15, 64'd15};
  bit     csat [3] = '{1'b0, 1'b0, 1'b1};
  longint m_eof [3], m_bad [3], m_last [3], m_max [3];
  bit     m_ovf [3];
  longint cur_words;

  function automatic void model_reset();
    cur_words = 0;
    for (int k = 0; k < 3; k++) begin
      m_eof[k] = 0; m_bad[k] = 0; m_last[k] = 0; m_max[k] = 0; m_ovf[k] = 1'b0;
    end
  endfunction

  function automatic void model_step(input bit v, input bit e, input bit b, input bit en, input bit clr);
    bit     have_len = 1'b0;
    longint len = 0;
    longint l;
    if (v) begin
      cur_words++;
      if (e) begin
        have_len  = 1'b1;
        len       = cur_words;
        cur_words = 0;
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (clr) begin
        m_eof[k] = 0; m_bad[k] = 0; m_last[k] = 0; m_max[k] = 0; m_ovf[k] = 1'b0;
      end else if (have_len) begin
        l = (len > lmax[k]) ? lmax[k] : len;
        m_last[k] = l;
        if (l > m_max[k]) m_max[k] = l;
        if (en && !b) begin
          if (m_eof[k] == cmax[k]) begin
            m_ovf[k] = 1'b1;
            if (!csat[k]) m_eof[k] = 0;
          end else m_eof[k]++;
        end
        if (en && b) begin
          if (m_bad[k] == cmax[k]) begin
            m_ovf[k] = 1'b1;
            if (!csat[k]) m_bad[k] = 0;
          end else m_bad[k]++;
        end
      end
    end
  endfunction

  // Drive one cycle: inputs set away from the edge, model advanced at the edge,
  // outputs left stable for sampling at the following falling edge.
  task automatic cycle(input bit v, input bit e, input bit b, input bit en, input bit clr);
    rx_valid = v; rx_eof = e; rx_bad_frame = b; ctr_en = en; ctr_clr = clr;
    @(posedge user_clk);
    model_step(v, e, b, en, clr);
    @(negedge user_clk);
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".a.eof"},  a_eof,  m_eof[0]);
    check({tag, ".a.bad"},  a_bad,  m_bad[0]);
    check({tag, ".a.last"}, a_last, m_last[0]);
    check({tag, ".a.max"},  a_max,  m_max[0]);
    check({tag, ".a.ovf"},  a_ovf,  m_ovf[0]);
    check({tag, ".w.eof"},  w_eof,  m_eof[1]);
    check({tag, ".w.bad"},  w_bad,  m_bad[1]);
    check({tag, ".w.last"}, w_last, m_last[1]);
    check({tag, ".w.max"},  w_max,  m_max[1]);
    check({tag, ".w.ovf"},  w_ovf,  m_ovf[1]);
    check({tag, ".s.eof"},  s_eof,  m_eof[2]);
    check({tag, ".s.bad"},  s_bad,  m_bad[2]);
    check({tag, ".s.last"}, s_last, m_last[2]);
    check({tag, ".s.max"},  s_max,  m_max[2]);
    check({tag, ".s.ovf"},  s_ovf,  m_ovf[2]);
  endtask

  typedef struct {
    bit          valid, eof, bad, en, clr;
    logic [31:0] exp_eof, exp_bad;
    logic [15:0] exp_last, exp_max;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit v, input bit e, input bit b, input bit en, input bit clr,
                              input int xe, input int xb, input int xl, input int xm);
    vec_t r;
    r.valid = v; r.eof = e; r.bad = b; r.en = en; r.clr = clr;
    r.exp_eof = 32'(xe); r.exp_bad = 32'(xb); r.exp_last = 16'(xl); r.exp_max = 16'(xm);
    r.exp_ovf = 1'b0;
    vecs.push_back(r);
  endfunction

  initial begin
    user_rst_n = 1'b0;
    rx_valid = 1'b0; rx_eof = 1'b0; rx_bad_frame = 1'b0; ctr_en = 1'b0; ctr_clr = 1'b0;
    model_reset();

    // Directed table for the default instance, expectations worked by hand.
    for (int f = 0; f < 3; f++)
      for (int w = 0; w < 8; w++)
        add(1, w == 7, 0, 1, 0, f + int'(w == 7), 0,
            (w == 7 || f > 0) ? 8 : 0, (w == 7 || f > 0) ? 8 : 0);
    add(1, 0, 1, 1, 0, 3, 0, 8, 8);   // bad flag without eof is ignored
    add(1, 1, 1, 1, 0, 3, 1, 2, 8);
    add(0, 1, 1, 1, 0, 3, 1, 2, 8);   // eof/bad ignored while not valid
    add(1, 1, 0, 1, 0, 4, 1, 1, 8);   // single-word frame
    add(1, 1, 0, 1, 1, 0, 0, 0, 0);   // clear beats a simultaneous eof
    add(1, 1, 0, 1, 0, 1, 0, 1, 1);
    for (int f = 0; f < 5; f++)
      for (int w = 0; w < 6; w++)
        add(1, w == 5, 0, 0, 0, 1, 0, (w == 5 || f > 0) ? 6 : 1, (w == 5 || f > 0) ? 6 : 1);
    add(1, 0, 0, 1, 0, 1, 0, 6, 6);   // clear mid-frame keeps the word count
    add(1, 0, 0, 1, 1, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 1, 0, 3, 3);

    repeat (2) @(negedge user_clk);
    check("rst.a.eof", a_eof, 0);
    check("rst.a.last", a_last, 0);
    check("rst.a.max", a_max, 0);
    check("rst.a.ovf", a_ovf, 0);
    user_rst_n = 1'b1;
    @(negedge user_clk);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].valid, vecs[i].eof, vecs[i].bad, vecs[i].en, vecs[i].clr);
      check($sformatf("vec%0d.eof", i),  a_eof,  vecs[i].exp_eof);
      check($sformatf("vec%0d.bad", i),  a_bad,  vecs[i].exp_bad);
      check($sformatf("vec%0d.last", i), a_last, vecs[i].exp_last);
      check($sformatf("vec%0d.max", i),  a_max,  vecs[i].exp_max);
      check($sformatf("vec%0d.ovf", i),  a_ovf,  vecs[i].exp_ovf);
    end

    // Counter wrap (dut_w) and saturation (dut_s) on 4-bit counters.
    cycle(0, 0, 0, 1, 1);
    for (int i = 0; i < 15; i++) cycle(1, 1, 0, 1, 0);
    check("pre_wrap.w.eof", w_eof, 15);
    check("pre_wrap.w.ovf", w_ovf, 0);
    check("pre_wrap.s.eof", s_eof, 15);
    check("pre_wrap.s.ovf", s_ovf, 0);
    cycle(1, 1, 0, 1, 0);
    check("wrap.w.eof", w_eof, 0);
    check("wrap.w.ovf", w_ovf, 1);
    check("sat.s.eof", s_eof, 15);
    check("sat.s.ovf", s_ovf, 1);
    check("wrap.a.eof", a_eof, 16);
    cycle(1, 1, 0, 1, 0);
    check("post_wrap.w.eof", w_eof, 1);
    check("post_wrap.w.ovf_sticky", w_ovf, 1);
    check("post_sat.s.eof", s_eof, 15);
    cycle(0, 0, 0, 1, 1);
    check("clr.w.ovf", w_ovf, 0);
    check("clr.s.ovf", s_ovf, 0);

    // 20-word frame with gaps: 4-bit length fields saturate at 15.
    for (int i = 0; i < 20; i++) begin
      cycle(1, i == 19, 0, 1, 0);
      if (i % 3 == 0 && i != 19) cycle(0, 1, 1, 1, 0);
    end
    check("lensat.s.last", s_last, 15);
    check("lensat.s.max", s_max, 15);
    check("lensat.w.last", w_last, 15);
    check("lensat.a.last", a_last, 20);
    check("lensat.a.max", a_max, 20);
    compare_all("lensat");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) < 8, $urandom_range(0, 39) == 0);
      compare_all($sformatf("rnd%0d", i));
    end

    // Asynchronous reset mid-frame, asserted and checked between clock edges.
    cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 0, 1, 0);
    rx_valid = 1'b0; rx_eof = 1'b0; ctr_clr = 1'b0;
    #1 user_rst_n = 1'b0;
    #1;
    check("arst.a.eof", a_eof, 0);
    check("arst.a.bad", a_bad, 0);
    check("arst.a.last", a_last, 0);
    check("arst.a.max", a_max, 0);
    check("arst.w.ovf", w_ovf, 0);
    check("arst.s.eof", s_eof, 0);
    model_reset();
    #1 user_rst_n = 1'b1;
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, i == 3, 0, 1, 0);
    check("arst_frame.a.last", a_last, 4);
    check("arst_frame.a.eof", a_eof, 1);
    compare_all("arst_frame");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
